// File: rtl/vga_pkg.sv
// Shared VGA timing constants, timing record and colour expansion helper.
// Used by vga_timing_gen; optional test pattern gated by VGA_TEST_PATTERN_EN.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef struct packed {
    logic [15:0] h_active, h_fp, h_sync, h_bp;
    logic [15:0] v_active, v_fp, v_sync, v_bp;
  } vga_timing_t;

  // Per-pixel timing flags carried down the delay line (1 = asserted)
  typedef struct packed {
    logic hs, vs, act, first, col0;
  } vga_flags_t;

  function automatic int h_total(input vga_timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

  // Replicate in_w-bit value MSB-first into out_w bits (out_w <= 16)
  function automatic logic [15:0] vga_expand(input logic [15:0] in, input int in_w, input int out_w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < out_w) r[4'(out_w - 1 - i)] = in[4'(in_w - 1 - (i % in_w))];
    return r;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// W x DEPTH shift register with synchronous reset value; DEPTH 0 is a wire.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
)(
  input  logic         vgaclk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = vgaclk ^ rst;
      assign q = d;
    end else begin : g_sr
      logic [DEPTH-1:0][W-1:0] sr;
      always_ff @(posedge vgaclk) begin
        if (rst) sr <= {DEPTH{RST_VAL}};
        else begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end
      assign q = sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// VGA counters, PIPE-aligned sync/DE/strobes and colour expansion to pins.
// Define VGA_TEST_PATTERN_EN to enable the test_en colour-bar generator.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = H_ACTIVE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_ACTIVE  = V_ACTIVE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CW_R      = 3,
  parameter int   CW_G      = 3,
  parameter int   CW_B      = 2,
  parameter int   CW_OUT    = 4,
  parameter int   PIPE      = 2,
  localparam vga_timing_t TIM = '{16'(H_ACTIVE), 16'(H_FP), 16'(H_SYNC), 16'(H_BP),
                                  16'(V_ACTIVE), 16'(V_FP), 16'(V_SYNC), 16'(V_BP)},
  localparam int  H_TOT     = h_total(TIM),
  localparam int  V_TOT     = v_total(TIM),
  localparam int  HCW       = $clog2(H_TOT),
  localparam int  VCW       = $clog2(V_TOT)
)(
  input  logic              vgaclk,
  input  logic              rst,
  input  logic [CW_R-1:0]   input_red,
  input  logic [CW_G-1:0]   input_green,
  input  logic [CW_B-1:0]   input_blue,
  input  logic              test_en,
  output logic [HCW-1:0]    hc_out,
  output logic [VCW-1:0]    vc_out,
  output logic              req_active,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic              line_start,
  output logic [CW_OUT-1:0] red,
  output logic [CW_OUT-1:0] green,
  output logic [CW_OUT-1:0] blue
);
  generate
    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
        CW_R > CW_OUT || CW_G > CW_OUT || CW_B > CW_OUT || CW_OUT > 16 ||
        PIPE < 0 || PIPE > 4) begin : g_bad_cfg
      $error("vga_timing_gen: illegal parameter set");
    end
  endgenerate

  localparam logic [HCW-1:0] H_ACT  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOT - 1);
  localparam logic [VCW-1:0] V_ACT  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_BEG = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOT - 1);

  logic [HCW-1:0] hc;
  logic [VCW-1:0] vc;
  vga_flags_t     raw, dly;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + VCW'(1);
    end else begin
      hc <= hc + HCW'(1);
    end
  end

  assign hc_out     = hc;
  assign vc_out     = vc;
  assign req_active = (hc < H_ACT) && (vc < V_ACT);

  always_comb begin
    raw       = '0;
    raw.hs    = (hc >= HS_BEG) && (hc < HS_END);
    raw.vs    = (vc >= VS_BEG) && (vc < VS_END);
    raw.act   = req_active;
    raw.first = (hc == '0) && (vc == '0);
    raw.col0  = (hc == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int DW = $bits(vga_flags_t) + HCW;
  logic [HCW-1:0] col_d;
  logic [2:0]     bar;
  logic [DW-1:0]  dly_in, dly_out;
  assign dly_in       = {raw, hc};
  assign {dly, col_d} = dly_out;
  assign bar          = 3'((32'(col_d) * 8) / H_ACTIVE);
`else
  localparam int DW = $bits(vga_flags_t);
  logic [DW-1:0]  dly_in, dly_out;
  logic           test_en_unused;
  assign test_en_unused = test_en;
  assign dly_in         = raw;
  assign dly            = dly_out;
`endif

  // Inactive flags in every stage, so reset never leaks a stale pixel to the pins
  vga_delay_line #(.W(DW), .DEPTH(PIPE), .RST_VAL('0)) u_dly (
    .vgaclk (vgaclk),
    .rst    (rst),
    .d      (dly_in),
    .q      (dly_out)
  );

  logic [CW_OUT-1:0] r_nx, g_nx, b_nx;

  always_comb begin
    r_nx = '0;
    g_nx = '0;
    b_nx = '0;
    if (dly.act) begin
      r_nx = CW_OUT'(vga_expand(16'(input_red),   CW_R, CW_OUT));
      g_nx = CW_OUT'(vga_expand(16'(input_green), CW_G, CW_OUT));
      b_nx = CW_OUT'(vga_expand(16'(input_blue),  CW_B, CW_OUT));
`ifdef VGA_TEST_PATTERN_EN
      if (test_en) begin
        r_nx = {CW_OUT{bar[2]}};
        g_nx = {CW_OUT{bar[1]}};
        b_nx = {CW_OUT{bar[0]}};
      end
`endif
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      hsync       <= dly.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= dly.vs ? VSYNC_POL : ~VSYNC_POL;
      de          <= dly.act;
      frame_start <= dly.first;
      line_start  <= dly.col0;
      red         <= r_nx;
      green       <= g_nx;
      blue        <= b_nx;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 PIPE=2 instance plus a tiny PIPE=0 instance.
module tb_vga_timing_gen;
  logic vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int scyc    = 0;

  logic       rst = 1'b1, rst_s = 1'b1, test_en = 1'b0;
  logic [2:0] input_red = 3'b101, input_green = 3'b011;
  logic [1:0] input_blue = 2'b10;

  logic [9:0] hc_out, vc_out;
  logic       req_active, hsync, vsync, de, frame_start, line_start;
  logic [3:0] red, green, blue;

  logic [3:0] s_hc;
  logic [2:0] s_vc;
  logic       s_req, s_hsync, s_vsync, s_de, s_fs, s_ls;
  logic [3:0] s_red, s_green, s_blue;

  vga_timing_gen u_dut (
    .vgaclk(vgaclk), .rst(rst), .input_red(input_red), .input_green(input_green),
    .input_blue(input_blue), .test_en(test_en), .hc_out(hc_out), .vc_out(vc_out),
    .req_active(req_active), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .line_start(line_start), .red(red), .green(green), .blue(blue)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE(0)
  ) u_sml (
    .vgaclk(vgaclk), .rst(rst_s), .input_red(input_red), .input_green(input_green),
    .input_blue(input_blue), .test_en(test_en), .hc_out(s_hc), .vc_out(s_vc),
    .req_active(s_req), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .frame_start(s_fs), .line_start(s_ls), .red(s_red), .green(s_green), .blue(s_blue)
  );

  task automatic tick();
    @(negedge vgaclk);
    cyc++;
    scyc++;
  endtask

  task automatic test_reset();
    repeat (5) @(posedge vgaclk);
    @(negedge vgaclk);
    n_tests++;
    if ({hsync, vsync} !== 2'b11) begin n_fail++; $display("FAIL reset_sync: got %b want 11", {hsync, vsync}); end
    n_tests++;
    if ({de, frame_start, line_start} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {de, frame_start, line_start}); end
    n_tests++;
    if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", {red, green, blue}); end
    rst = 1'b0;
    cyc = 0;
    n_tests++;
    if (hc_out !== 10'd0 || vc_out !== 10'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d,%0d want 0,0", hc_out, vc_out); end
  endtask

  task automatic test_first_pixel();
    repeat (2) tick();
    n_tests++;
    if (de !== 1'b0) begin n_fail++; $display("FAIL early_de: got %b want 0 at cycle %0d", de, cyc); end
    tick();
    n_tests++;
    if ({de, frame_start, line_start} !== 3'b111) begin n_fail++; $display("FAIL first_pixel: got %b want 111", {de, frame_start, line_start}); end
    n_tests++;
    if ({red, green, blue} !== 12'hB6A) begin n_fail++; $display("FAIL first_rgb: got %h want B6A", {red, green, blue}); end
  endtask

  task automatic test_hsync_line();
    int first_lo = -1, rise = -1, lows = 0, de_cnt = 0, bad_rgb = 0;
    while (cyc < 803) begin
      tick();
      if (hsync === 1'b0) begin
        lows++;
        if (first_lo < 0) first_lo = cyc;
      end else if (first_lo >= 0 && rise < 0) rise = cyc;
      if (de === 1'b1) begin
        de_cnt++;
        if ({red, green, blue} !== 12'hB6A) bad_rgb++;
      end else if ({red, green, blue} !== 12'h000) bad_rgb++;
      if (cyc == 659) begin
        n_tests++;
        if (hc_out !== 10'd659) begin n_fail++; $display("FAIL hc_track: got %0d want 659", hc_out); end
      end
    end
    n_tests++;
    if (first_lo != 659) begin n_fail++; $display("FAIL hsync_start: got %0d want 659", first_lo); end
    n_tests++;
    if (lows != 96) begin n_fail++; $display("FAIL hsync_width: got %0d want 96", lows); end
    n_tests++;
    if (rise != 755) begin n_fail++; $display("FAIL hsync_end: got %0d want 755", rise); end
    n_tests++;
    if (de_cnt != 640) begin n_fail++; $display("FAIL de_count: got %0d want 640", de_cnt); end
    n_tests++;
    if (bad_rgb != 0) begin n_fail++; $display("FAIL rgb_blank: got %0d bad cycles want 0", bad_rgb); end
    n_tests++;
    if ({line_start, frame_start} !== 2'b10) begin n_fail++; $display("FAIL line_period: got ls/fs %b want 10", {line_start, frame_start}); end
  endtask

  task automatic test_pattern();
    logic [11:0] exp0, exp80, exp560;
`ifdef VGA_TEST_PATTERN_EN
    exp0 = 12'h000; exp80 = 12'h00F; exp560 = 12'hFFF;
`else
    exp0 = 12'hB6A; exp80 = 12'hB6A; exp560 = 12'hB6A;
`endif
    test_en = 1'b1;
    while (cyc < 1603) tick();
    n_tests++;
    if ({red, green, blue} !== exp0) begin n_fail++; $display("FAIL pat_col0: got %h want %h", {red, green, blue}, exp0); end
    while (cyc < 1683) tick();
    n_tests++;
    if ({red, green, blue} !== exp80) begin n_fail++; $display("FAIL pat_col80: got %h want %h", {red, green, blue}, exp80); end
    while (cyc < 2163) tick();
    n_tests++;
    if ({red, green, blue} !== exp560) begin n_fail++; $display("FAIL pat_col560: got %h want %h", {red, green, blue}, exp560); end
    while (cyc < 2303) tick();
    n_tests++;
    if ({de, red, green, blue} !== 13'h0000) begin n_fail++; $display("FAIL pat_blank: got %h want 0000", {de, red, green, blue}); end
    test_en = 1'b0;
  endtask

  task automatic test_small_line();
    int first_hi = -1, his = 0, de_cnt = 0;
    n_tests++;
    if ({s_hsync, s_vsync, s_de} !== 3'b010) begin n_fail++; $display("FAIL s_reset: got %b want 010", {s_hsync, s_vsync, s_de}); end
    rst_s = 1'b0;
    scyc  = 0;
    while (scyc < 17) begin
      tick();
      if (scyc <= 16) begin
        if (s_hsync === 1'b1) begin his++; if (first_hi < 0) first_hi = scyc; end
        if (s_de === 1'b1) de_cnt++;
      end
      if (scyc == 7 || scyc == 8) begin
        n_tests++;
        if (s_req !== (scyc == 7)) begin n_fail++; $display("FAIL s_req: got %b at hc %0d", s_req, scyc); end
      end
    end
    n_tests++;
    if (first_hi != 11) begin n_fail++; $display("FAIL s_hsync_start: got %0d want 11", first_hi); end
    n_tests++;
    if (his != 3) begin n_fail++; $display("FAIL s_hsync_width: got %0d want 3", his); end
    n_tests++;
    if (de_cnt != 8) begin n_fail++; $display("FAIL s_de_count: got %0d want 8", de_cnt); end
    n_tests++;
    if (s_ls !== 1'b1) begin n_fail++; $display("FAIL s_line_start: got %b want 1", s_ls); end
  endtask

  task automatic test_small_frame();
    int first_lo = -1, lows = 0, fs_cnt = 0;
    while (scyc < 260) begin
      tick();
      if (s_vsync === 1'b0) begin lows++; if (first_lo < 0) first_lo = scyc; end
      if (s_fs === 1'b1) fs_cnt++;
      if (scyc == 127) begin
        n_tests++;
        if ({s_hc, s_vc} !== {4'd15, 3'd7}) begin n_fail++; $display("FAIL s_last: got %0d,%0d want 15,7", s_hc, s_vc); end
      end
      if (scyc == 128) begin
        n_tests++;
        if ({s_hc, s_vc} !== 7'd0) begin n_fail++; $display("FAIL s_wrap: got %0d,%0d want 0,0", s_hc, s_vc); end
      end
      if (scyc == 129) begin
        n_tests++;
        if (s_fs !== 1'b1) begin n_fail++; $display("FAIL s_frame_start: got %b want 1", s_fs); end
      end
    end
    n_tests++;
    if (first_lo != 81) begin n_fail++; $display("FAIL s_vsync_start: got %0d want 81", first_lo); end
    n_tests++;
    if (lows != 64) begin n_fail++; $display("FAIL s_vsync_width: got %0d want 64", lows); end
    n_tests++;
    if (fs_cnt != 2) begin n_fail++; $display("FAIL s_frame_count: got %0d want 2", fs_cnt); end
  endtask

  task automatic test_mid_reset();
    while (scyc < 293) tick();
    n_tests++;
    if ({s_hc, s_vc} !== {4'd5, 3'd2}) begin n_fail++; $display("FAIL s_pos: got %0d,%0d want 5,2", s_hc, s_vc); end
    rst_s = 1'b1;
    tick();
    n_tests++;
    if ({s_hc, s_vc} !== 7'd0) begin n_fail++; $display("FAIL s_rst_cnt: got %0d,%0d want 0,0", s_hc, s_vc); end
    n_tests++;
    if ({s_hsync, s_vsync, s_de, s_fs} !== 4'b0100) begin n_fail++; $display("FAIL s_rst_pins: got %b want 0100", {s_hsync, s_vsync, s_de, s_fs}); end
    rst_s = 1'b0;
    tick();
    n_tests++;
    if ({s_fs, s_ls, s_de} !== 3'b111) begin n_fail++; $display("FAIL s_restart: got %b want 111", {s_fs, s_ls, s_de}); end
    n_tests++;
    if ({s_red, s_green, s_blue} !== 12'hB6A) begin n_fail++; $display("FAIL s_rgb: got %h want B6A", {s_red, s_green, s_blue}); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_hsync_line();
    test_pattern();
    test_small_line();
    test_small_frame();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised next-generation VGA timing and pixel-output stage, running on the pixel clock.
- Generates horizontal/vertical counters with fully parametrised porch/sync/active lengths and sync polarity.
- Presents request coordinates to the graphics module PIPE cycles ahead of the pins, so a pipelined colour source lines up.
- Expands arbitrary-width input colour to the pin width by bit replication, and emits registered sync, data-enable and frame/line strobes.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync asserted level (0 = active-low)
VSYNC_POL, 0, vsync asserted level (0 = active-low)
CW_R / CW_G / CW_B, 3 / 3 / 2, input colour widths
CW_OUT, 4, output width per channel
PIPE, 2, colour-source latency in cycles (legal 0..4)

Ports:
vgaclk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
input_red  in  CW_R  colour for the coordinate requested PIPE cycles earlier
input_green  in  CW_G  as above
input_blue  in  CW_B  as above
test_en  in  1  select internal test pattern (see Optional Feature)
hc_out  out  HCW  request column, HCW = $clog2(H total)
vc_out  out  VCW  request line, VCW = $clog2(V total)
req_active  out  1  request coordinate is inside the visible area
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
de  out  1  pin-side data enable
frame_start  out  1  one-cycle pulse, pin-side pixel (0,0)
line_start  out  1  one-cycle pulse, pin-side column 0 of any line
red / green / blue  out  CW_OUT  pixel colour

Behaviour:
- H_TOT = sum of the H_* lengths; V_TOT likewise.
- Elaboration $error if any length is 0, any CW_* > CW_OUT, or PIPE > 4.
- Counters:
  - hc runs 0..H_TOT-1. On wrap, vc increments; vc wraps at V_TOT-1 to 0.
  - hc_out/vc_out are the counters directly.
  - req_active = hc<H_ACTIVE && vc<V_ACTIVE.
- Raw timing from the counters:
  - hsync asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); it is not gated by hc.
- Raw hsync/vsync/active/first-pixel/first-column flags pass through a PIPE-stage delay line, then an output register.
- Colour inputs are sampled in the same cycle the delayed flags reach the output register.
- Total pin latency from counter value to pins is PIPE+1 cycles, identical for every output.
- Colour expansion: output = input replicated MSB-first and truncated to CW_OUT. Defaults: 3b abc -> abca, 2b ab -> abab.
- RGB is forced to 0 when the delayed active flag is 0.
- Reset:
  - hc = vc = 0.
  - All delay stages hold the blanking/inactive state.
  - Pins: hsync = ~HSYNC_POL, vsync = ~VSYNC_POL; de, frame_start, line_start and RGB = 0.
- Reset mid-frame returns to the reset state on the next edge; no partial line or sync pulse is completed.
- First visible pixel appears on the pins PIPE+1 cycles after the first non-reset edge, with frame_start = line_start = de = 1.
- Simultaneous hc and vc wrap: both counters go to 0 on the same edge.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined and test_en = 1: input colours are ignored and eight equal-width vertical colour bars are generated from the delayed column.
  - Bar index = column*8/H_ACTIVE; bit2 = R, bit1 = G, bit0 = B, full scale.
  - Bar 7 = white (F,F,F), bar 0 = black.
  - Blanking rules are unchanged.
- When undefined, test_en is ignored and the pattern logic is absent.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants;
  - a vga_timing_t struct of the eight length fields;
  - the replicate-expand function (in, in_w, out_w).
- One sub-module, vga_delay_line: a parametrised width × depth shift register with synchronous reset value. Depth 0 is a pass-through.

Test Plan:
1. Defaults, reset held 5 cycles then released. hsync stays 1 until cycle 659; it is 0 for cycles 659..754 (96 cycles) and returns to 1 at cycle 755. Line period is 800.
2. Frame timing: vsync low exactly 1600 cycles (2 lines), starting at line 490 + 3 cycles. frame_start fires every 420000 cycles.
3. Input colour R=3'b101, G=3'b011, B=2'b10 held constant. While de is 1, pins read red=4'hB, green=4'h6, blue=4'hA; during blanking all are 0.
4. PIPE=0, HSYNC_POL=1, H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOT 16). hsync is high for counter 10..12 and appears 1 cycle later; de lasts 8 cycles per line.
5. Assert rst at hc=300, vc=100 for 1 cycle. Counters read 0,0 on the next edge; sync pins are inactive; frame_start follows PIPE+1 later.
6. With VGA_TEST_PATTERN_EN and test_en=1: pin-side column 0 shows 0,0,0; column 80 shows 0,0,F; column 560 shows F,F,F.
